// File: rtl/plic_claim_agent.sv
// Hart-side APB4 requester that claims interrupt IDs from the PLIC CLAIM/COMPLETE register,
// hands each ID to the core over valid/ready, and writes it back once the core signals done.
module plic_claim_agent #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] CLAIM_OFFSET   = 32'h24,
    parameter int          ID_WIDTH       = 5,
    parameter int          SPUR_CNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      en_i,
    input  logic                      irq_i,
    output logic [31:0]               paddr_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [31:0]               pwdata_o,
    output logic [3:0]                pstrb_o,
    output logic [2:0]                pprot_o,
    input  logic [31:0]               prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i,
    output logic                      id_valid_o,
    output logic [ID_WIDTH-1:0]       id_o,
    input  logic                      id_ready_i,
    input  logic                      done_i,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [SPUR_CNT_WIDTH-1:0] spur_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        CLM_SETUP,
        CLM_ACCESS,
        DELIVER,
        WAIT_DONE,
        CMP_SETUP,
        CMP_ACCESS
    } state_t;

    localparam logic [31:0] CLAIM_ADDR = BASE_ADDR + CLAIM_OFFSET;

    state_t              state;
    logic [ID_WIDTH-1:0] rd_id;
    logic                unused_rdata;

    assign rd_id        = prdata_i[ID_WIDTH-1:0];
    assign unused_rdata = &{1'b0, prdata_i[31:ID_WIDTH]};
    assign pprot_o      = 3'b000;

    // Handshake: the ID transfers on any cycle where id_valid_o && id_ready_i at the rising edge;
    // id_valid_o and id_o stay frozen until then. APB follows SETUP then ACCESS, held until pready_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            paddr_o    <= '0;
            psel_o     <= 1'b0;
            penable_o  <= 1'b0;
            pwrite_o   <= 1'b0;
            pwdata_o   <= '0;
            pstrb_o    <= '0;
            id_valid_o <= 1'b0;
            id_o       <= '0;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
            spur_cnt_o <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i && irq_i) begin
                        state     <= CLM_SETUP;
                        busy_o    <= 1'b1;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        pwrite_o  <= 1'b0;
                        pstrb_o   <= 4'h0;
                        paddr_o   <= CLAIM_ADDR;
                    end
                end
                CLM_SETUP: begin
                    state     <= CLM_ACCESS;
                    penable_o <= 1'b1;
                end
                CLM_ACCESS: begin
                    if (pready_i) begin
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        if (pslverr_i) begin
                            err_o  <= 1'b1;
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else if (rd_id == '0) begin
                            // ID 0 means the PLIC had nothing pending by the time we read it.
                            if (spur_cnt_o != '1) begin
                                spur_cnt_o <= spur_cnt_o + 1'b1;
                            end
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            id_o       <= rd_id;
                            id_valid_o <= 1'b1;
                            state      <= DELIVER;
                        end
                    end
                end
                DELIVER: begin
                    if (id_ready_i) begin
                        id_valid_o <= 1'b0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (done_i) begin
                        state     <= CMP_SETUP;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        pwrite_o  <= 1'b1;
                        pwdata_o  <= {{(32-ID_WIDTH){1'b0}}, id_o};
                        pstrb_o   <= 4'hF;
                    end
                end
                CMP_SETUP: begin
                    state     <= CMP_ACCESS;
                    penable_o <= 1'b1;
                end
                CMP_ACCESS: begin
                    if (pready_i) begin
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        pwrite_o  <= 1'b0;
                        pstrb_o   <= 4'h0;
                        err_o     <= pslverr_i;
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    psel_o     <= 1'b0;
                    penable_o  <= 1'b0;
                    id_valid_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plic_claim_agent.sv
// Directed bench for plic_claim_agent: an APB responder, a scoreboard queue of expected
// APB/ID/error events, and a negedge monitor that pops and compares each observed event.
module tb_plic_claim_agent;

    localparam int W = 72;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        en_i = 1'b0;
    logic        irq_i = 1'b0;
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [2:0]  pprot_o;
    logic [31:0] prdata_i = '0;
    logic        pready_i = 1'b0;
    logic        pslverr_i = 1'b0;
    logic        id_valid_o;
    logic [4:0]  id_o;
    logic        id_ready_i = 1'b0;
    logic        done_i = 1'b0;
    logic        busy_o;
    logic        err_o;
    logic [7:0]  spur_cnt_o;

    // responder configuration
    int          rd_wait = 0;
    int          wr_wait = 0;
    logic [31:0] rd_data = '0;
    logic        rd_err = 1'b0;
    logic        wr_err = 1'b0;
    int          wait_cnt = 0;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int spur_exp = 0;

    plic_claim_agent #(
        .BASE_ADDR(32'h0000_0000),
        .CLAIM_OFFSET(32'h24),
        .ID_WIDTH(5),
        .SPUR_CNT_WIDTH(8)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .en_i(en_i),
        .irq_i(irq_i),
        .paddr_o(paddr_o),
        .psel_o(psel_o),
        .penable_o(penable_o),
        .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o),
        .pstrb_o(pstrb_o),
        .pprot_o(pprot_o),
        .prdata_i(prdata_i),
        .pready_i(pready_i),
        .pslverr_i(pslverr_i),
        .id_valid_o(id_valid_o),
        .id_o(id_o),
        .id_ready_i(id_ready_i),
        .done_i(done_i),
        .busy_o(busy_o),
        .err_o(err_o),
        .spur_cnt_o(spur_cnt_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_rd();
        exp_q.push_back({4'd1, 4'h0, 32'h24, 32'h0});
    endtask

    task automatic push_wr(input int id);
        exp_q.push_back({4'd2, 4'hF, 32'h24, 32'(id)});
    endtask

    task automatic push_id(input int id);
        exp_q.push_back({4'd3, 4'h0, 32'h0, 32'(id)});
    endtask

    task automatic push_err();
        exp_q.push_back({4'd4, 68'h0});
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    task automatic wait_busy_low(input string nm);
        int n = 0;
        while (busy_o && n < 60) begin
            tick();
            n++;
        end
        check(nm, W'(busy_o), W'(0));
    endtask

    task automatic wait_id_valid(input string nm, output int n);
        n = 0;
        while (!id_valid_o && n < 60) begin
            tick();
            n++;
        end
        check(nm, W'(id_valid_o), W'(1));
    endtask

    // APB responder: decides pready just after each edge from the freshly registered psel/penable
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (psel_o && penable_o) begin
                if (wait_cnt < (pwrite_o ? wr_wait : rd_wait)) begin
                    pready_i  = 1'b0;
                    pslverr_i = 1'b0;
                    wait_cnt++;
                end else begin
                    pready_i  = 1'b1;
                    prdata_i  = pwrite_o ? 32'h0 : rd_data;
                    pslverr_i = pwrite_o ? wr_err : rd_err;
                end
            end else begin
                pready_i  = 1'b0;
                pslverr_i = 1'b0;
                prdata_i  = '0;
                wait_cnt  = 0;
            end
        end
    end

    // monitor: every observed transfer, ID handshake or error pulse is popped against the queue
    task automatic expect_ev(input string nm, input logic [W-1:0] act);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got unexpected event %0h, expected none", nm, act);
        end else begin
            check(nm, act, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [68:0] setup_v;
        setup_v = '0;
        forever begin
            @(negedge clk_i);
            if (rst_n_i) begin
                if (psel_o && !penable_o) begin
                    setup_v = {pwrite_o, paddr_o, pwdata_o, pstrb_o};
                end
                if (psel_o && penable_o) begin
                    check("apb_stable", W'({pwrite_o, paddr_o, pwdata_o, pstrb_o}), W'(setup_v));
                    if (pready_i) begin
                        expect_ev("apb_xfer", {pwrite_o ? 4'd2 : 4'd1, pstrb_o, paddr_o,
                                               pwrite_o ? pwdata_o : 32'h0});
                    end
                end
                if (id_valid_o && id_ready_i) begin
                    expect_ev("id_handshake", {4'd3, 4'h0, 32'h0, 27'h0, id_o});
                end
                if (err_o) begin
                    expect_ev("err_pulse", {4'd4, 68'h0});
                end
            end
        end
    end

    initial begin
        int n;

        // reset state
        repeat (3) tick();
        check("rst_apb", W'({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o}), W'(0));
        check("rst_core", W'({id_valid_o, id_o, busy_o, err_o, spur_cnt_o}), W'(0));
        rst_n_i = 1'b1;
        tick();

        // basic claim, zero-wait APB
        en_i = 1'b1;
        id_ready_i = 1'b1;
        rd_data = 32'd7;
        push_rd();
        push_id(7);
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        check("basic_setup", W'({psel_o, penable_o, pwrite_o, busy_o, paddr_o}), W'({4'b1001, 32'h24}));
        tick();
        check("basic_access", W'({psel_o, penable_o}), W'(2'b11));
        tick();
        check("basic_deliver", W'({id_valid_o, id_o, psel_o}), W'({1'b1, 5'd7, 1'b0}));
        tick();
        check("basic_wait_done", W'({id_valid_o, busy_o}), W'(2'b01));
        push_wr(7);
        pulse_done();
        check("basic_cmp_setup", W'({psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o}),
              W'({3'b101, 4'hF, 32'd7}));
        tick();
        check("basic_cmp_access", W'({psel_o, penable_o, busy_o}), W'(3'b111));
        tick();
        check("basic_idle", W'({psel_o, penable_o, busy_o}), W'(3'b000));

        // wait states on both accesses; upper read-data bits are ignored
        rd_wait = 4;
        wr_wait = 2;
        rd_data = 32'hFFFF_FFE3;
        push_rd();
        push_id(3);
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        wait_id_valid("ws_id_valid", n);
        check("ws_latency", W'(n + 1), W'(7));
        check("ws_id", W'(id_o), W'(3));
        tick();
        push_wr(3);
        pulse_done();
        wait_busy_low("ws_idle");
        rd_wait = 0;
        wr_wait = 0;

        // spurious claims, saturating counter
        rd_data = 32'h0;
        for (int i = 0; i < 300; i++) begin
            push_rd();
            irq_i = 1'b1;
            tick();
            irq_i = 1'b0;
            wait_busy_low("spur_idle");
            spur_exp = (spur_exp == 255) ? 255 : spur_exp + 1;
            if (i == 0) check("spur_first", W'(spur_cnt_o), W'(1));
        end
        check("spur_sat", W'(spur_cnt_o), W'(spur_exp));
        check("spur_sat_255", W'(spur_cnt_o), W'(255));

        // slave error on the claim read
        rd_data = 32'd9;
        rd_err = 1'b1;
        push_rd();
        push_err();
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        wait_busy_low("clm_err_idle");
        tick();
        check("clm_err_nodeliver", W'({id_valid_o, spur_cnt_o}), W'({1'b0, 8'd255}));
        rd_err = 1'b0;

        // delivery backpressure, early done ignored, error on completion write
        rd_data = 32'd12;
        wr_err = 1'b1;
        id_ready_i = 1'b0;
        push_rd();
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        wait_id_valid("bp_id_valid", n);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", W'({id_valid_o, id_o}), W'({1'b1, 5'd12}));
            done_i = (i == 1);
            tick();
        end
        done_i = 1'b0;
        push_id(12);
        id_ready_i = 1'b1;
        tick();
        check("bp_valid_drop", W'(id_valid_o), W'(0));
        for (int i = 0; i < 3; i++) begin
            check("bp_no_write", W'({psel_o, busy_o}), W'(2'b01));
            tick();
        end
        push_wr(12);
        push_err();
        pulse_done();
        wait_busy_low("bp_idle");
        wr_err = 1'b0;

        // enable low blocks new claims
        en_i = 1'b0;
        irq_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("en_low_quiet", W'({psel_o, busy_o}), W'(2'b00));
        end

        // irq held high: second claim starts one cycle after returning to IDLE
        rd_data = 32'd4;
        push_rd();
        push_id(4);
        en_i = 1'b1;
        wait_id_valid("rc_id_valid", n);
        tick();
        push_wr(4);
        pulse_done();
        wait_busy_low("rc_idle");
        rd_data = 32'd6;
        push_rd();
        push_id(6);
        tick();
        check("rc_restart", W'({psel_o, penable_o, busy_o}), W'(3'b101));
        irq_i = 1'b0;
        wait_id_valid("rc2_id_valid", n);
        check("rc2_id", W'(id_o), W'(6));
        tick();

        // reset asserted during the completion write
        wr_wait = 10;
        pulse_done();
        tick();
        check("rst_cmp_access", W'({psel_o, penable_o, pwrite_o}), W'(3'b111));
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_rst_apb", W'({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o}), W'(0));
        check("async_rst_core", W'({id_valid_o, id_o, busy_o, err_o, spur_cnt_o}), W'(0));
        tick();
        tick();
        rst_n_i = 1'b1;
        wr_wait = 0;
        repeat (4) tick();
        check("post_rst_idle", W'({psel_o, busy_o, spur_cnt_o}), W'(0));

        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plic_claim_agent.md
Name: plic_claim_agent

Overview:
- Hart-side counterpart of the APB4 PLIC slave. Acts as an APB4 requester (master) toward the PLIC register file.
- When the PLIC interrupt line is asserted, it reads the CLAIM/COMPLETE register to claim an interrupt ID.
- It hands the ID to the core over a valid/ready handshake, waits for the core's service-done pulse, then writes the ID back to CLAIM/COMPLETE.
- Sits between the PLIC `irq_o` and a simple core or firmware interrupt interface.

Parameters:
- BASE_ADDR, 32'h0000_0000, PLIC APB base address.
- CLAIM_OFFSET, 32'h24, byte offset of CLAIM/COMPLETE (word index 9).
- ID_WIDTH, 5, width of the interrupt ID (supports up to 31 sources).
- SPUR_CNT_WIDTH, 8, width of the spurious-claim counter.

Ports:
- clk_i  in  1  APB clock, also the block clock.
- rst_n_i  in  1  reset, asynchronous active-low.
- en_i  in  1  agent enable; when low, no new claim starts.
- irq_i  in  1  level interrupt from the PLIC (`irq_o`).
- paddr_o  out  32  APB address.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB write.
- pwdata_o  out  32  APB write data.
- pstrb_o  out  4  APB strobes; always 4'hF on write, 4'h0 on read.
- pprot_o  out  3  constant 3'b000.
- prdata_i  in  32  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB error.
- id_valid_o  out  1  claimed ID available to the core.
- id_o  out  ID_WIDTH  claimed interrupt ID.
- id_ready_i  in  1  core accepts the ID.
- done_i  in  1  one-cycle pulse: the core has finished servicing `id_o`.
- busy_o  out  1  high whenever the state is not IDLE.
- err_o  out  1  one-cycle pulse on `pslverr_i` during any access.
- spur_cnt_o  out  SPUR_CNT_WIDTH  count of claims that returned ID 0.

Behaviour:
- Reset values (all outputs):
  - `paddr_o`, `pwdata_o`, `pstrb_o`, `id_o`, `spur_cnt_o` = 0.
  - `psel_o`, `penable_o`, `pwrite_o`, `id_valid_o`, `busy_o`, `err_o` = 0.
  - State = IDLE. Reset asserted mid-transfer aborts immediately; no completion is issued.
- FSM states: IDLE, CLM_SETUP, CLM_ACCESS, DELIVER, WAIT_DONE, CMP_SETUP, CMP_ACCESS.
- IDLE: if `en_i` && `irq_i` -> CLM_SETUP on the next edge.
- CLM_SETUP (1 cycle):
  - `psel_o`=1, `penable_o`=0, `pwrite_o`=0, `paddr_o`=BASE_ADDR+CLAIM_OFFSET.
  - -> CLM_ACCESS.
- CLM_ACCESS: `psel_o`=`penable_o`=1; address and control held stable. Hold while `pready_i`=0. When `pready_i`=1:
  - If `pslverr_i`: pulse `err_o`, -> IDLE.
  - Else, with id = `prdata_i`[ID_WIDTH-1:0]:
    - id==0: `spur_cnt_o`++ (saturates at all-ones), -> IDLE.
    - id!=0: latch into `id_o`, -> DELIVER.
- DELIVER: `id_valid_o`=1 and `id_o` stable until `id_ready_i`. On the valid&&ready cycle -> WAIT_DONE; `id_valid_o` drops the next cycle.
- WAIT_DONE: wait for a `done_i` pulse, then -> CMP_SETUP. `done_i` outside WAIT_DONE is ignored.
- CMP_SETUP (1 cycle): `psel_o`=1, `pwrite_o`=1, `pwdata_o`=zero-extended `id_o`, `pstrb_o`=4'hF; -> CMP_ACCESS.
- CMP_ACCESS: `penable_o`=1; hold until `pready_i`.
  - On `pslverr_i`: pulse `err_o`.
  - Either way -> IDLE.
- `psel_o`/`penable_o` deassert in the cycle after the access completes.
- Minimum idle gap between transfers: one cycle.
- `en_i` deassertion:
  - Affects only the IDLE->CLM_SETUP decision.
  - A claim already in flight runs to completion; delivery and completion are never abandoned.
- `irq_i` changes after claim start are ignored until the state returns to IDLE.
- If `irq_i` is still high on return to IDLE, a new claim starts one cycle later.
- Latency, `irq_i` rise to `id_valid_o` (zero-wait APB): 3 edges (IDLE->CLM_SETUP->CLM_ACCESS->DELIVER).
- `done_i` to CMP_SETUP: 1 edge.
- `busy_o` = (state != IDLE), registered with the state.

Test Plan:
- Basic claim:
  - Stimulus: `irq_i`=1, `en_i`=1, `pready_i`=1, `prdata_i`=7, `id_ready_i`=1.
  - Response: APB read at 0x24 (SETUP then ACCESS); `id_valid_o`=1 with `id_o`=7 on the 3rd edge.
  - Then `done_i` pulse -> APB write at 0x24, `pwdata_o`=7, `pstrb_o`=4'hF; `busy_o` drops after the write.
- Wait states: `pready_i`=0 for 4 cycles in CLM_ACCESS and 2 in CMP_ACCESS -> `paddr_o`, `pwrite_o`, `pwdata_o` stable throughout; each phase completes on the `pready_i`=1 cycle.
- Spurious claim: `prdata_i`=0 -> no `id_valid_o`, no write, `spur_cnt_o` 0->1, back to IDLE. With 300 spurious claims and SPUR_CNT_WIDTH=8 -> `spur_cnt_o`=255.
- Error response: `pslverr_i`=1 on the claim read -> `err_o` 1-cycle pulse, no delivery.
- Delivery backpressure: `pslverr_i`=1 on the complete write -> `err_o` pulse, returns to IDLE. `id_ready_i` low for 5 cycles -> `id_valid_o`/`id_o` held; `done_i` pulsed during DELIVER is ignored (no write until the next `done_i` in WAIT_DONE).
- Enable, re-claim and reset:
  - `en_i` low with `irq_i` high -> no APB activity.
  - `irq_i` held high through the whole sequence -> a second claim starts exactly 1 cycle after returning to IDLE.
  - `rst_n_i` low during CMP_ACCESS -> all outputs 0 asynchronously; no write completes.
